// File: rtl/signal_skid_buffer.sv
// Two-entry skid buffer with a valid/ready handshake on each side.
// in_ready comes only from flops, so there is no combinational path from
// out_ready or in_valid to in_ready. A sticky flag records upstream
// handshake violations.
module signal_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid;
    logic [WIDTH-1:0] prev_data;
    logic             prev_stall;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Occupancy state, main (out_data) and skid registers, and registered flags.
    // in_ready is held low through reset and rises at the first edge after it,
    // which makes it the ready-enable flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data   <= '0;
            skid       <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
            count      <= 2'd0;
            proto_err  <= 1'b0;
            prev_stall <= 1'b0;
            prev_data  <= '0;
        end else begin
            prev_stall <= in_valid & ~in_ready;
            prev_data  <= in_data;
            if (prev_stall && (!in_valid || (in_data != prev_data))) begin
                proto_err <= 1'b1;
            end

            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        count     <= 2'd1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            skid     <= in_data;
                            in_ready <= 1'b0;
                            count    <= 2'd2;
                            state    <= FULL;
                        end
                        2'b01: begin
                            out_valid <= 1'b0;
                            count     <= 2'd0;
                            state     <= EMPTY;
                        end
                        2'b11: begin
                            out_data <= in_data;
                        end
                        default: begin
                        end
                    endcase
                end
                FULL: begin
                    if (out_fire) begin
                        out_data <= skid;
                        in_ready <= 1'b1;
                        count    <= 2'd1;
                        state    <= BUSY;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    count     <= 2'd0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/signal_skid_buffer.md
SIGNAL_SKID_BUFFER -- requirements
Module: signal_skid_buffer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, payload width in bits (legal 1..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts payload this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-007 The block SHALL have port out_valid, output, 1 bit: downstream payload valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accepts payload.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: downstream payload.
REQ-010 The block SHALL have port count, output, 2 bits: occupancy 0..2.
REQ-011 The block SHALL have port proto_err, output, 1 bit: sticky upstream protocol-violation flag.

Function
REQ-012 The block SHALL define in-fire as in_valid & in_ready and out-fire as out_valid & out_ready, both sampled at the rising clk edge.
REQ-013 The block SHALL implement three states: EMPTY (0 entries), BUSY (main register holds 1 entry) and FULL (main and skid registers both hold entries).
REQ-014 In EMPTY, on in-fire the block SHALL load main from in_data and go to BUSY; otherwise it SHALL stay in EMPTY.
REQ-015 In BUSY, on in-fire without out-fire the block SHALL load skid from in_data and go to FULL.
REQ-016 In BUSY, on out-fire without in-fire the block SHALL go to EMPTY.
REQ-017 In BUSY, on simultaneous in-fire and out-fire the block SHALL load main from in_data and stay in BUSY.
REQ-018 In FULL, on out-fire the block SHALL copy skid into main and go to BUSY; in-fire is impossible in FULL.
REQ-019 out_valid SHALL be 1 exactly when the state is BUSY or FULL, and out_data SHALL always equal the main register.
REQ-020 in_ready SHALL be 1 exactly when the state is not FULL and the ready-enable flop is set.
REQ-021 in_ready SHALL be driven from registers only, with no combinational path from out_ready or in_valid.
REQ-022 Latency SHALL be 1 cycle: a payload accepted at edge N appears on out_data with out_valid=1 after edge N when it becomes the head entry.
REQ-023 Ordering SHALL be strict FIFO; no payload is duplicated or dropped.
REQ-024 count SHALL read 0, 1 or 2 for EMPTY, BUSY or FULL respectively.
REQ-025 proto_err SHALL set when, in the previous cycle, in_valid=1 and in_ready=0, and in the current cycle in_valid=0 or in_data differs from its previous value.
REQ-026 Once set, proto_err SHALL stay set until reset; it SHALL have no effect on the data path.
REQ-027 When out_valid=1 and out_ready=0, out_data SHALL be held stable.

Reset
REQ-028 While rst_n=0, the state SHALL be EMPTY, count=0, out_valid=0, in_ready=0 and proto_err=0, all asynchronously.
REQ-029 out_data SHALL reset to 0.
REQ-030 The ready-enable flop SHALL set at the first rising clk edge after rst_n deasserts, so in_ready=1 from that edge onward.
REQ-031 Reset asserted mid-transfer SHALL discard both entries; no payload held before reset SHALL appear after it.

Verification
REQ-032 Reset then idle: after the first edge, in_ready=1, out_valid=0 and count=0; with in_valid held at 0 these stay constant.
REQ-033 Streaming: with out_ready=1, drive 0x01..0x10 on consecutive cycles; out_data SHALL show 0x01..0x10 in order, one per cycle, and count SHALL stay at 1.
REQ-034 Backpressure: with out_ready=0, send 0xA5 then 0x5A; the response SHALL be count=2 and in_ready=0.
REQ-035 Backpressure release: from REQ-034, raise out_ready; the outputs SHALL be 0xA5 then 0x5A, and in_ready SHALL return to 1 one cycle after the first out-fire.
REQ-036 Protocol error: in FULL, hold in_valid=1 with 0x33, then change in_data to 0x34 while in_ready=0; proto_err SHALL go to 1 and remain 1 through subsequent traffic.
REQ-037 Reset mid-operation: in FULL, pulse rst_n low; count SHALL go to 0 and out_valid to 0 immediately, and no pre-reset payload SHALL emerge afterward.
